// File: rtl/shield_power_sequencer.sv
// shield_power_sequencer
//   Power / level-shifter sequencing for two shield slots (A = 0, B = 1).
//   Power-up order: supply on -> settle -> LOE -> HOE; power-down is the reverse.
//   Over-current flags are synchronised and run-length filtered. A filtered
//   over-current shuts the slot down and schedules a retry after a cooldown.
//   Once the retry budget is spent the slot latches FAULTED until cleared.
// Ports
//   csi_MCLK_clk / rsi_MRST_reset : clock, synchronous active-high reset
//   avs_Ctrl_*                    : Avalon-MM slave (CTRL, STAT, IRQEN), no wait states
//   ins_OC_irq                    : registered OR of pending & enabled over-current flags
//   coe_X_OCN                     : over-current flag, active low, asynchronous
//   coe_X_PWREN                   : supply enable, active low
//   coe_X_HOE / coe_X_LOE         : high-/low-side buffer enables, active high
module shield_power_sequencer #(
  parameter int SETTLE_CYCLES   = 50000,
  parameter int OE_DELAY        = 1000,
  parameter int COOLDOWN_CYCLES = 5000000,
  parameter int OC_FILTER       = 4,
  parameter int MAX_RETRY       = 3
) (
  input  logic        csi_MCLK_clk,
  input  logic        rsi_MRST_reset,
  input  logic [1:0]  avs_Ctrl_address,
  input  logic [31:0] avs_Ctrl_writedata,
  output logic [31:0] avs_Ctrl_readdata,
  input  logic [3:0]  avs_Ctrl_byteenable,
  input  logic        avs_Ctrl_write,
  input  logic        avs_Ctrl_read,
  output logic        avs_Ctrl_waitrequest,
  output logic        ins_OC_irq,
  input  logic        coe_A_OCN,
  input  logic        coe_B_OCN,
  output logic        coe_A_PWREN,
  output logic        coe_B_PWREN,
  output logic        coe_A_HOE,
  output logic        coe_B_HOE,
  output logic        coe_A_LOE,
  output logic        coe_B_LOE
);

  typedef enum logic [2:0] {
    S_OFF     = 3'd0,
    S_SETTLE  = 3'd1,
    S_LOE     = 3'd2,
    S_ON      = 3'd3,
    S_DOWN    = 3'd4,
    S_COOL    = 3'd5,
    S_FAULTED = 3'd6
  } state_t;

  localparam logic [23:0] SETTLE_LOAD = 24'(SETTLE_CYCLES - 1);
  localparam logic [23:0] OE_LOAD     = 24'(OE_DELAY - 1);
  localparam logic [23:0] COOL_LOAD   = 24'(COOLDOWN_CYCLES - 1);
  localparam logic [1:0]  RETRY_MAX   = 2'(MAX_RETRY);
  localparam int          RW          = $clog2(OC_FILTER + 1);

  logic clk;
  logic srst;
  assign clk  = csi_MCLK_clk;
  assign srst = rsi_MRST_reset;

  // ---------------- register interface ----------------
  logic [1:0] req_reg, req_next;
  logic [1:0] irqen_reg, irqen_next;
  logic [1:0] clr;
  logic [1:0] w1c;
  logic       irq_reg;

  logic wr_ctrl, wr_stat, wr_irqen;
  assign wr_ctrl  = avs_Ctrl_write && (avs_Ctrl_address == 2'd0);
  assign wr_stat  = avs_Ctrl_write && (avs_Ctrl_address == 2'd1);
  assign wr_irqen = avs_Ctrl_write && (avs_Ctrl_address == 2'd2);

  // The slot FSMs look at the value being written so that REQ and CLR both
  // act on the same edge that captures the write.
  always_comb begin
    req_next   = req_reg;
    irqen_next = irqen_reg;
    clr        = 2'b00;
    w1c        = 2'b00;
    if (wr_ctrl && avs_Ctrl_byteenable[0]) req_next   = avs_Ctrl_writedata[1:0];
    if (wr_ctrl && avs_Ctrl_byteenable[1]) clr        = avs_Ctrl_writedata[9:8];
    if (wr_stat && avs_Ctrl_byteenable[2]) w1c        = avs_Ctrl_writedata[17:16];
    if (wr_irqen && avs_Ctrl_byteenable[0]) irqen_next = avs_Ctrl_writedata[1:0];
  end

  logic [1:0] ocn;
  assign ocn = {coe_B_OCN, coe_A_OCN};

  logic [1:0][2:0] st;
  logic [1:0][1:0] retry;
  logic [1:0]      pend;
  logic [1:0]      pend_next;
  logic [1:0]      pwren;
  logic [1:0]      loe;
  logic [1:0]      hoe;

  // ---------------- per-slot logic ----------------
  for (genvar gi = 0; gi < 2; gi++) begin : g_slot
    logic          sync1_reg, sync2_reg;
    logic [RW-1:0] run_reg;
    logic          oc_det;
    state_t        state_reg, state_next;
    logic [23:0]   cnt_reg, cnt_next;
    logic [1:0]    retry_reg, retry_next;
    logic          pend_reg;
    logic          pwren_reg, loe_reg, hoe_reg;
    logic          active;

    // Run length saturates at OC_FILTER, so a single pulse is produced per low
    // run; only a synced-high sample resets the run and re-arms detection.
    assign oc_det = !sync2_reg && (run_reg == RW'(OC_FILTER - 1));

    always_ff @(posedge clk) begin
      if (srst) begin
        sync1_reg <= 1'b1;
        sync2_reg <= 1'b1;
        run_reg   <= '0;
      end else begin
        sync1_reg <= ocn[gi];
        sync2_reg <= sync1_reg;
        if (sync2_reg)
          run_reg <= '0;
        else if (run_reg != RW'(OC_FILTER))
          run_reg <= run_reg + 1'b1;
      end
    end

    assign active = (state_reg == S_SETTLE) || (state_reg == S_LOE) ||
                    (state_reg == S_ON)     || (state_reg == S_DOWN);

    always_comb begin
      state_next = state_reg;
      cnt_next   = (cnt_reg != 24'd0) ? cnt_reg - 24'd1 : cnt_reg;
      retry_next = retry_reg;
      if (oc_det && active) begin
        if (retry_reg < RETRY_MAX) begin
          retry_next = retry_reg + 2'd1;
          state_next = S_COOL;
          cnt_next   = COOL_LOAD;
        end else begin
          state_next = S_FAULTED;
        end
      end else if (oc_det) begin
        // Idle states only record the event; freeze the slot for this cycle.
        cnt_next = cnt_reg;
      end else begin
        if (clr[gi]) retry_next = 2'd0;
        case (state_reg)
          S_OFF: begin
            if (req_next[gi]) begin
              state_next = S_SETTLE;
              cnt_next   = SETTLE_LOAD;
            end
          end
          S_SETTLE: begin
            if (cnt_reg == 24'd0) begin
              state_next = S_LOE;
              cnt_next   = OE_LOAD;
            end
          end
          S_LOE: begin
            if (cnt_reg == 24'd0) state_next = S_ON;
          end
          S_ON: begin
            if (!req_next[gi]) begin
              state_next = S_DOWN;
              cnt_next   = OE_LOAD;
            end
          end
          S_DOWN: begin
            if (cnt_reg == 24'd0) begin
              state_next = S_OFF;
              retry_next = 2'd0;
            end
          end
          S_COOL: begin
            if (!req_next[gi]) begin
              state_next = S_OFF;
              retry_next = 2'd0;
            end else if (cnt_reg == 24'd0) begin
              state_next = S_SETTLE;
              cnt_next   = SETTLE_LOAD;
            end
          end
          S_FAULTED: begin
            if (clr[gi]) begin
              state_next = S_OFF;
              retry_next = 2'd0;
            end
          end
          default: state_next = S_OFF;
        endcase
      end
    end

    assign pend_next[gi] = (pend_reg & ~w1c[gi]) | oc_det;

    always_ff @(posedge clk) begin
      if (srst) begin
        state_reg <= S_OFF;
        cnt_reg   <= 24'd0;
        retry_reg <= 2'd0;
        pend_reg  <= 1'b0;
        pwren_reg <= 1'b1;
        loe_reg   <= 1'b0;
        hoe_reg   <= 1'b0;
      end else begin
        state_reg <= state_next;
        cnt_reg   <= cnt_next;
        retry_reg <= retry_next;
        pend_reg  <= pend_next[gi];
        // Outputs follow the state being entered, so they change on the same
        // edge as the state register.
        pwren_reg <= !((state_next == S_SETTLE) || (state_next == S_LOE) ||
                       (state_next == S_ON)     || (state_next == S_DOWN));
        loe_reg   <= (state_next == S_LOE) || (state_next == S_ON);
        hoe_reg   <= (state_next == S_ON);
      end
    end

    assign st[gi]    = state_reg;
    assign retry[gi] = retry_reg;
    assign pend[gi]  = pend_reg;
    assign pwren[gi] = pwren_reg;
    assign loe[gi]   = loe_reg;
    assign hoe[gi]   = hoe_reg;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      req_reg   <= 2'b00;
      irqen_reg <= 2'b00;
      irq_reg   <= 1'b0;
    end else begin
      req_reg   <= req_next;
      irqen_reg <= irqen_next;
      irq_reg   <= |(pend_next & irqen_next);
    end
  end

  always_comb begin
    avs_Ctrl_readdata = 32'd0;
    case (avs_Ctrl_address)
      2'd0: avs_Ctrl_readdata = {30'd0, req_reg};
      2'd1: avs_Ctrl_readdata = {6'd0, (st[1] == S_FAULTED), (st[0] == S_FAULTED),
                                 2'd0, retry[1], retry[0], pend[1], pend[0],
                                 5'd0, st[1], 5'd0, st[0]};
      2'd2: avs_Ctrl_readdata = {30'd0, irqen_reg};
      default: avs_Ctrl_readdata = 32'd0;
    endcase
  end

  assign avs_Ctrl_waitrequest = 1'b0;
  assign ins_OC_irq  = irq_reg;
  assign coe_A_PWREN = pwren[0];
  assign coe_B_PWREN = pwren[1];
  assign coe_A_LOE   = loe[0];
  assign coe_B_LOE   = loe[1];
  assign coe_A_HOE   = hoe[0];
  assign coe_B_HOE   = hoe[1];

  logic unused_ok;
  assign unused_ok = ^{avs_Ctrl_writedata[31:18], avs_Ctrl_writedata[15:10],
                       avs_Ctrl_writedata[7:2], avs_Ctrl_byteenable[3], avs_Ctrl_read};

endmodule

// File: tb/tb_shield_power_sequencer.sv
// tb_shield_power_sequencer
//   Directed bench for shield_power_sequencer with small timing parameters.
//   A cycle-level behavioural model (phase + cycles-remaining per slot, over-current
//   detection from a history of raw OCN samples) is compared against the DUT on every
//   negative edge; literal expectations at key points pin the model itself.
module tb_shield_power_sequencer;
  localparam int SETTLE = 10;
  localparam int OED    = 4;
  localparam int COOLD  = 20;
  localparam int FILT   = 2;
  localparam int MAXR   = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  address = 2'd1;
  logic [31:0] wdata = 32'd0;
  logic [3:0]  be = 4'd0;
  logic        write = 1'b0;
  logic        read = 1'b0;
  logic [31:0] rdata;
  logic        waitreq;
  logic        irq;
  logic        a_ocn = 1'b1, b_ocn = 1'b1;
  logic        a_pwren, b_pwren, a_hoe, b_hoe, a_loe, b_loe;

  always #5 clk = ~clk;

  shield_power_sequencer #(
    .SETTLE_CYCLES(SETTLE), .OE_DELAY(OED), .COOLDOWN_CYCLES(COOLD),
    .OC_FILTER(FILT), .MAX_RETRY(MAXR)
  ) dut (
    .csi_MCLK_clk(clk), .rsi_MRST_reset(rst),
    .avs_Ctrl_address(address), .avs_Ctrl_writedata(wdata),
    .avs_Ctrl_readdata(rdata), .avs_Ctrl_byteenable(be),
    .avs_Ctrl_write(write), .avs_Ctrl_read(read),
    .avs_Ctrl_waitrequest(waitreq), .ins_OC_irq(irq),
    .coe_A_OCN(a_ocn), .coe_B_OCN(b_ocn),
    .coe_A_PWREN(a_pwren), .coe_B_PWREN(b_pwren),
    .coe_A_HOE(a_hoe), .coe_B_HOE(b_hoe),
    .coe_A_LOE(a_loe), .coe_B_LOE(b_loe)
  );

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  // ---------------- behavioural model ----------------
  logic [1:0] m_req = 2'b00, m_irqen = 2'b00, m_pend = 2'b00;
  bit         m_irq = 1'b0;
  int         m_st[2], m_left[2], m_rt[2];
  bit         hist[2][8];   // hist[s][0] = raw OCN captured at the latest edge

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [1:0] a);
    logic [31:0] r;
    r = 32'd0;
    case (a)
      2'd0: r = {30'd0, m_req};
      2'd1: begin
        r[2:0]   = 3'(m_st[0]);
        r[10:8]  = 3'(m_st[1]);
        r[16]    = m_pend[0];
        r[17]    = m_pend[1];
        r[19:18] = 2'(m_rt[0]);
        r[21:20] = 2'(m_rt[1]);
        r[24]    = (m_st[0] == 6);
        r[25]    = (m_st[1] == 6);
      end
      2'd2: r = {30'd0, m_irqen};
      default: r = 32'd0;
    endcase
    return r;
  endfunction

  function automatic bit powered(input int s);
    return (s >= 1) && (s <= 4);
  endfunction

  task automatic model_edge();
    logic [1:0] req_n, clr, w1c, raw;
    bit oc;
    raw = {b_ocn, a_ocn};
    if (rst) begin
      m_req = 0; m_irqen = 0; m_pend = 0; m_irq = 0;
      for (int s = 0; s < 2; s++) begin
        m_st[s] = 0; m_left[s] = 0; m_rt[s] = 0;
        for (int k = 0; k < 8; k++) hist[s][k] = 1'b1;
      end
      return;
    end
    req_n = m_req; clr = 0; w1c = 0;
    if (write && address == 2'd0 && be[0]) req_n = wdata[1:0];
    if (write && address == 2'd0 && be[1]) clr = wdata[9:8];
    if (write && address == 2'd1 && be[2]) w1c = wdata[17:16];
    if (write && address == 2'd2 && be[0]) m_irqen = wdata[1:0];
    m_req = req_n;
    for (int s = 0; s < 2; s++) begin
      for (int k = 7; k > 0; k--) hist[s][k] = hist[s][k-1];
      hist[s][0] = raw[s];
      // Decision at this edge uses the raw value from two edges ago: a fresh
      // run of exactly FILT lows preceded by a high.
      oc = (hist[s][FILT+2] == 1'b1);
      for (int j = 0; j < FILT; j++) if (hist[s][2+j] != 1'b0) oc = 1'b0;
      m_pend[s] = (m_pend[s] & ~w1c[s]) | oc;
      if (oc && powered(m_st[s])) begin
        if (m_rt[s] < MAXR) begin
          m_rt[s]++; m_st[s] = 5; m_left[s] = COOLD;
        end else begin
          m_st[s] = 6;
        end
      end else if (!oc) begin
        if (clr[s]) m_rt[s] = 0;
        case (m_st[s])
          0: if (req_n[s]) begin m_st[s] = 1; m_left[s] = SETTLE; end
          1: if (m_left[s] == 1) begin m_st[s] = 2; m_left[s] = OED; end else m_left[s]--;
          2: if (m_left[s] == 1) m_st[s] = 3; else m_left[s]--;
          3: if (!req_n[s]) begin m_st[s] = 4; m_left[s] = OED; end
          4: if (m_left[s] == 1) begin m_st[s] = 0; m_rt[s] = 0; end else m_left[s]--;
          5: if (!req_n[s]) begin m_st[s] = 0; m_rt[s] = 0; end
             else if (m_left[s] == 1) begin m_st[s] = 1; m_left[s] = SETTLE; end
             else m_left[s]--;
          6: if (clr[s]) begin m_st[s] = 0; m_rt[s] = 0; end
          default: m_st[s] = 0;
        endcase
      end
    end
    m_irq = |(m_pend & m_irqen);
  endtask

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      check("pwren", {30'd0, b_pwren, a_pwren},
            {30'd0, !powered(m_st[1]), !powered(m_st[0])});
      check("loe", {30'd0, b_loe, a_loe},
            {30'd0, (m_st[1] == 2 || m_st[1] == 3), (m_st[0] == 2 || m_st[0] == 3)});
      check("hoe", {30'd0, b_hoe, a_hoe}, {30'd0, (m_st[1] == 3), (m_st[0] == 3)});
      check("irq", {31'd0, irq}, {31'd0, m_irq});
      check("readdata", rdata, m_read(address));
      check("waitrequest", {31'd0, waitreq}, 32'd0);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    cmp_en = 1'b1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] b);
    address = a; wdata = d; be = b; write = 1'b1;
    step();
    write = 1'b0; be = 4'd0; wdata = 32'd0; address = 2'd1;
    $display("WR addr=%0d data=0x%08h be=%b", a, d, b);
  endtask

  task automatic rd_check(input string name, input logic [1:0] a, input logic [31:0] exp);
    address = a;
    #1;
    check(name, rdata, exp);
    $display("RD %s addr=%0d data=0x%08h", name, a, rdata);
    address = 2'd1;
  endtask

  int n;

  initial begin
    idle(3);
    rst = 1'b0;
    check("reset_pwren", {30'd0, b_pwren, a_pwren}, 32'd3);
    rd_check("reset_stat", 2'd1, 32'd0);

    wr(2'd2, 32'h1, 4'b0001);

    // power-up timing on slot A
    wr(2'd0, 32'h1, 4'b0001);
    check("pwren_fall", {30'd0, b_pwren, a_pwren}, 32'd2);
    n = 0;
    while (!a_loe && n < 100) begin step(); n++; end
    check("settle_len", n, SETTLE);
    n = 0;
    while (!a_hoe && n < 100) begin step(); n++; end
    check("oe_len", n, OED);

    // power-down timing
    wr(2'd0, 32'h0, 4'b0001);
    check("down_oe_off", {30'd0, a_hoe, a_loe}, 32'd0);
    n = 0;
    while (!a_pwren && n < 100) begin step(); n++; end
    check("down_len", n, OED);

    // back on, then a one-cycle OCN glitch is filtered out
    wr(2'd0, 32'h1, 4'b0001);
    idle(16);
    a_ocn = 1'b0; step(); a_ocn = 1'b1;
    idle(6);
    rd_check("glitch_ignored", 2'd1, 32'h0000_0003);

    // real over-current: PEND, COOL, retry=1, irq
    a_ocn = 1'b0; idle(3); a_ocn = 1'b1;
    idle(3);
    rd_check("oc_cool", 2'd1, 32'h0005_0005);
    check("oc_irq", {31'd0, irq}, 32'd1);
    wr(2'd1, 32'h0001_0000, 4'b0100);
    check("w1c_irq", {31'd0, irq}, 32'd0);
    rd_check("w1c_stat", 2'd1, 32'h0004_0005);

    // cooldown expires, slot re-sequences; retry is kept
    idle(40);
    rd_check("retry_on", 2'd1, 32'h0004_0003);

    // second fault -> COOL retry=2, third fault during SETTLE -> FAULTED
    a_ocn = 1'b0; idle(3); a_ocn = 1'b1;
    idle(25);
    a_ocn = 1'b0; idle(3); a_ocn = 1'b1;
    idle(2);
    rd_check("faulted", 2'd1, 32'h0109_0006);
    idle(10);
    check("faulted_off", {29'd0, a_pwren, a_hoe, a_loe}, 32'd4);

    // clear PEND, then CLR with REQ held -> OFF, restart
    wr(2'd1, 32'h0001_0000, 4'b0100);
    wr(2'd0, 32'h0000_0101, 4'b0011);
    rd_check("clr_off", 2'd1, 32'h0000_0000);
    idle(20);
    rd_check("restart_on", 2'd1, 32'h0000_0003);

    // REQ drop coinciding with oc_det -> COOL, then OFF
    a_ocn = 1'b0; idle(3);
    wr(2'd0, 32'h0, 4'b0001);
    a_ocn = 1'b1;
    rd_check("oc_beats_down", 2'd1, 32'h0005_0005);
    step();
    rd_check("cool_to_off", 2'd1, 32'h0001_0000);
    wr(2'd1, 32'h0001_0000, 4'b0100);

    // slot B on; byte-lane write that only reaches the CLR bits
    wr(2'd0, 32'h2, 4'b0001);
    idle(20);
    rd_check("b_on", 2'd1, 32'h0000_0300);
    wr(2'd0, 32'h0000_0303, 4'b0010);
    rd_check("be_ctrl", 2'd0, 32'h0000_0002);
    rd_check("be_stat", 2'd1, 32'h0000_0300);

    // reset mid-SETTLE on A and ON on B
    wr(2'd0, 32'h3, 4'b0001);
    idle(4);
    rst = 1'b1;
    step();
    check("rst_pwren", {30'd0, b_pwren, a_pwren}, 32'd3);
    check("rst_oe", {28'd0, b_hoe, b_loe, a_hoe, a_loe}, 32'd0);
    rd_check("rst_stat", 2'd1, 32'd0);
    rd_check("rst_ctrl", 2'd0, 32'd0);
    rst = 1'b0;
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end
endmodule
